// File: rtl/kronos_counter_csr.sv
// CSR access unit for the 64b cycle/instret counters: waits for the addressed
// counter to settle, returns the old 32b half, then pulses a one-cycle load.
module kronos_counter_csr #(
    parameter bit EN_COUNTERS    = 1'b1,
    parameter bit EN_COUNTERS64B = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [11:0] req_addr,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_wdata,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [63:0] cycle_count,
    input  logic        cycle_vld,
    input  logic [63:0] instret_count,
    input  logic        instret_vld,
    output logic [31:0] load_data,
    output logic        cycle_load_low,
    output logic        cycle_load_high,
    output logic        instret_load_low,
    output logic        instret_load_high
);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_r;
    logic [11:0] addr_r;
    logic [1:0]  op_r;
    logic [31:0] wdata_r;

    logic        legal_s;
    logic        ro_s;
    logic        high_s;
    logic        inst_s;
    logic        present_s;
    logic [63:0] cnt_s;
    logic        vld_s;
    logic [31:0] old_s;
    logic [31:0] new_s;
    logic        eff_write_s;
    logic        err_s;
    logic        ready_s;
    logic        do_load_s;

    // Address decode of the captured request
    always_comb begin
        legal_s = 1'b0;
        ro_s    = 1'b0;
        high_s  = 1'b0;
        inst_s  = 1'b0;
        case (addr_r)
            12'hB00: begin legal_s = 1'b1; end
            12'hB80: begin legal_s = 1'b1; high_s = 1'b1; end
            12'hB02: begin legal_s = 1'b1; inst_s = 1'b1; end
            12'hB82: begin legal_s = 1'b1; high_s = 1'b1; inst_s = 1'b1; end
            12'hC00: begin legal_s = 1'b1; ro_s = 1'b1; end
            12'hC80: begin legal_s = 1'b1; ro_s = 1'b1; high_s = 1'b1; end
            12'hC02: begin legal_s = 1'b1; ro_s = 1'b1; inst_s = 1'b1; end
            12'hC82: begin legal_s = 1'b1; ro_s = 1'b1; high_s = 1'b1; inst_s = 1'b1; end
            default: begin legal_s = 1'b0; end
        endcase
    end

    // Old/new value, error and load decision for the captured request
    always_comb begin
        // An absent counter half has nothing to wait for and reads as zero
        present_s = EN_COUNTERS && (!high_s || EN_COUNTERS64B);
        if (inst_s) begin
            cnt_s = instret_count;
            vld_s = instret_vld;
        end else begin
            cnt_s = cycle_count;
            vld_s = cycle_vld;
        end
        if (present_s) begin
            old_s = high_s ? cnt_s[63:32] : cnt_s[31:0];
        end else begin
            old_s = 32'd0;
        end
        eff_write_s = (op_r == OP_WRITE) || ((op_r != OP_READ) && (wdata_r != 32'd0));
        err_s       = !legal_s || (ro_s && eff_write_s);
        ready_s     = !legal_s || !present_s || vld_s;
        do_load_s   = !err_s && eff_write_s && present_s;
        case (op_r)
            OP_WRITE: new_s = wdata_r;
            OP_SET:   new_s = old_s | wdata_r;
            OP_CLEAR: new_s = old_s & ~wdata_r;
            default:  new_s = old_s;
        endcase
    end

    // Request FSM with registered handshake, response and load outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            addr_r            <= 12'd0;
            op_r              <= 2'd0;
            wdata_r           <= 32'd0;
            req_rdy           <= 1'b1;
            rsp_vld           <= 1'b0;
            rsp_rdata         <= 32'd0;
            rsp_err           <= 1'b0;
            load_data         <= 32'd0;
            cycle_load_low    <= 1'b0;
            cycle_load_high   <= 1'b0;
            instret_load_low  <= 1'b0;
            instret_load_high <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_vld && req_rdy) begin
                        addr_r  <= req_addr;
                        op_r    <= req_op;
                        wdata_r <= req_wdata;
                        req_rdy <= 1'b0;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ready_s) begin
                        rsp_rdata <= err_s ? 32'd0 : old_s;
                        rsp_err   <= err_s;
                        if (do_load_s) begin
                            load_data         <= new_s;
                            cycle_load_low    <= !inst_s && !high_s;
                            cycle_load_high   <= !inst_s && high_s;
                            instret_load_low  <= inst_s && !high_s;
                            instret_load_high <= inst_s && high_s;
                            state_r           <= ST_LOAD;
                        end else begin
                            rsp_vld <= 1'b1;
                            state_r <= ST_RESP;
                        end
                    end
                end
                ST_LOAD: begin
                    cycle_load_low    <= 1'b0;
                    cycle_load_high   <= 1'b0;
                    instret_load_low  <= 1'b0;
                    instret_load_high <= 1'b0;
                    rsp_vld           <= 1'b1;
                    state_r           <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        req_rdy <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r           <= ST_IDLE;
                    req_rdy           <= 1'b1;
                    rsp_vld           <= 1'b0;
                    cycle_load_low    <= 1'b0;
                    cycle_load_high   <= 1'b0;
                    instret_load_low  <= 1'b0;
                    instret_load_high <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_counter_csr.sv
// Directed self-checking bench for kronos_counter_csr.
module tb_kronos_counter_csr;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] cycle_count;
    logic        cycle_vld;
    logic [63:0] instret_count;
    logic        instret_vld;
    logic [31:0] load_data;
    logic        cycle_load_low;
    logic        cycle_load_high;
    logic        instret_load_low;
    logic        instret_load_high;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pulse_cnt = 0;
    int pc0;

    kronos_counter_csr dut (
        .clk               (clk),
        .rst               (rst),
        .req_vld           (req_vld),
        .req_rdy           (req_rdy),
        .req_addr          (req_addr),
        .req_op            (req_op),
        .req_wdata         (req_wdata),
        .rsp_vld           (rsp_vld),
        .rsp_rdy           (rsp_rdy),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .cycle_count       (cycle_count),
        .cycle_vld         (cycle_vld),
        .instret_count     (instret_count),
        .instret_vld       (instret_vld),
        .load_data         (load_data),
        .cycle_load_low    (cycle_load_low),
        .cycle_load_high   (cycle_load_high),
        .instret_load_low  (instret_load_low),
        .instret_load_high (instret_load_high)
    );

    always #5 clk = ~clk;

    // Count every cycle in which any load output is high
    always @(negedge clk) begin
        if (cycle_load_low || cycle_load_high || instret_load_low || instret_load_high)
            pulse_cnt <= pulse_cnt + 1;
    end

    function automatic logic [3:0] loads();
        return {cycle_load_low, cycle_load_high, instret_load_low, instret_load_high};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one request; returns #1 after the accepting edge
    task automatic send(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        chk("req_rdy_idle", {63'd0, req_rdy}, 64'd1);
        req_vld   = 1'b1;
        req_addr  = a;
        req_op    = op;
        req_wdata = wd;
        step();
        req_vld   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_addr = 12'd0; req_op = 2'd0; req_wdata = 32'd0;
        rsp_rdy = 1'b1;
        cycle_count = 64'h0000_0005_FFFF_FFF0; cycle_vld = 1'b1;
        instret_count = 64'h0000_0000_AAAA_5555; instret_vld = 1'b1;
        step(); step();
        chk("rst_rsp_vld", {63'd0, rsp_vld}, 64'd0);
        chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_load_data", {32'd0, load_data}, 64'd0);
        chk("rst_loads", {60'd0, loads()}, 64'd0);
        chk("rst_req_rdy", {63'd0, req_rdy}, 64'd1);
        rst = 1'b0;
        step();

        // Read mcycle, counter settled: response one cycle after accept
        pc0 = pulse_cnt;
        send(12'hB00, 2'd0, 32'd0);
        chk("rd_wait_rsp_vld", {63'd0, rsp_vld}, 64'd0);
        chk("rd_wait_req_rdy", {63'd0, req_rdy}, 64'd0);
        step();
        chk("rd_rsp_vld", {63'd0, rsp_vld}, 64'd1);
        chk("rd_rdata", {32'd0, rsp_rdata}, 64'hFFFF_FFF0);
        chk("rd_err", {63'd0, rsp_err}, 64'd0);
        step();
        chk("rd_done", {63'd0, rsp_vld}, 64'd0);
        chk("rd_no_pulse", pulse_cnt, pc0);

        // Read mcycleh with the counter unsettled for 3 cycles
        cycle_count = 64'h0000_0006_0000_0000; cycle_vld = 1'b0;
        send(12'hB80, 2'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdh_waiting", {63'd0, rsp_vld}, 64'd0);
        end
        cycle_vld = 1'b1;
        step();
        chk("rdh_rsp_vld", {63'd0, rsp_vld}, 64'd1);
        chk("rdh_rdata", {32'd0, rsp_rdata}, 64'h6);
        step();

        // WRITE minstret
        pc0 = pulse_cnt;
        send(12'hB02, 2'd1, 32'h0000_1234);
        step();
        chk("wr_loads", {60'd0, loads()}, 64'b0010);
        chk("wr_load_data", {32'd0, load_data}, 64'h1234);
        chk("wr_load_rsp_vld", {63'd0, rsp_vld}, 64'd0);
        step();
        chk("wr_rsp_vld", {63'd0, rsp_vld}, 64'd1);
        chk("wr_rdata", {32'd0, rsp_rdata}, 64'hAAAA_5555);
        chk("wr_loads_off", {60'd0, loads()}, 64'd0);
        chk("wr_one_pulse", pulse_cnt, pc0 + 1);
        step();

        // SET then CLEAR mcycleh
        cycle_count = 64'h0000_00F0_0000_0000;
        send(12'hB80, 2'd2, 32'h0000_000F);
        step();
        chk("set_loads", {60'd0, loads()}, 64'b0100);
        chk("set_load_data", {32'd0, load_data}, 64'hFF);
        step();
        chk("set_rdata", {32'd0, rsp_rdata}, 64'hF0);
        step();
        send(12'hB80, 2'd3, 32'h0000_000F);
        step();
        chk("clr_loads", {60'd0, loads()}, 64'b0100);
        chk("clr_load_data", {32'd0, load_data}, 64'hF0);
        step();
        chk("clr_rdata", {32'd0, rsp_rdata}, 64'hF0);
        step();

        // Read-only and illegal addresses
        cycle_count = 64'h0000_0005_FFFF_FFF0;
        pc0 = pulse_cnt;
        send(12'hC00, 2'd1, 32'h0000_0001);
        step();
        chk("ro_wr_rsp_vld", {63'd0, rsp_vld}, 64'd1);
        chk("ro_wr_err", {63'd0, rsp_err}, 64'd1);
        chk("ro_wr_rdata", {32'd0, rsp_rdata}, 64'd0);
        step();
        send(12'hC00, 2'd2, 32'd0);
        step();
        chk("ro_set0_err", {63'd0, rsp_err}, 64'd0);
        chk("ro_set0_rdata", {32'd0, rsp_rdata}, 64'hFFFF_FFF0);
        step();
        send(12'hB05, 2'd0, 32'd0);
        step();
        chk("ill_err", {63'd0, rsp_err}, 64'd1);
        chk("ill_rdata", {32'd0, rsp_rdata}, 64'd0);
        step();
        chk("err_no_pulse", pulse_cnt, pc0);

        // Reset while waiting on an unsettled counter
        cycle_vld = 1'b0;
        pc0 = pulse_cnt;
        send(12'hB00, 2'd1, 32'h0000_0001);
        step();
        rst = 1'b1; cycle_vld = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_rsp_vld", {63'd0, rsp_vld}, 64'd0);
        chk("rstw_req_rdy", {63'd0, req_rdy}, 64'd1);
        step(); step();
        chk("rstw_no_pulse", pulse_cnt, pc0);

        // Reset during the load cycle
        send(12'hB00, 2'd1, 32'h0000_0002);
        step();
        chk("rstl_in_load", {60'd0, loads()}, 64'b1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pc0 = pulse_cnt;
        chk("rstl_loads", {60'd0, loads()}, 64'd0);
        chk("rstl_rsp_vld", {63'd0, rsp_vld}, 64'd0);
        chk("rstl_req_rdy", {63'd0, req_rdy}, 64'd1);
        step(); step();
        chk("rstl_no_pulse", pulse_cnt, pc0);

        // Response held while the consumer stalls
        rsp_rdy = 1'b0;
        send(12'hB02, 2'd0, 32'd0);
        step();
        instret_count = 64'h0000_0000_0000_0077;
        for (int i = 0; i < 4; i++) begin
            chk("hold_rsp_vld", {63'd0, rsp_vld}, 64'd1);
            chk("hold_rdata", {32'd0, rsp_rdata}, 64'hAAAA_5555);
            step();
        end
        rsp_rdy = 1'b1;
        step();
        chk("hold_release", {63'd0, rsp_vld}, 64'd0);
        chk("hold_req_rdy", {63'd0, req_rdy}, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
